// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial ADD/SUB unit, STEP bits per cycle LSB first, with optional NZCV flags.
// Flags are only generated when SERIAL_ADD_SUB_FLAGS_EN is defined; otherwise they are tied to 0.
module serial_add_sub #(
  parameter int WIDTH = 64,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  if (WIDTH % STEP != 0) begin : g_bad_step
    $error("WIDTH must be a multiple of STEP");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic             carry_q, in_ready_q, out_valid_q, busy_q;
  logic [CW-1:0]    cnt_q;
  logic [STEP-1:0]  sum;
  logic [STEP:0]    cy;
  logic             last;
  // Ripple of STEP full adders fed by the registered carry; sum enters result from the MSB end.
  always_comb begin
    cy    = '0;
    sum   = '0;
    cy[0] = carry_q;
    for (int i = 0; i < STEP; i++) begin
      sum[i]   = a_q[i] ^ b_q[i] ^ cy[i];
      cy[i+1]  = (a_q[i] & b_q[i]) | (cy[i] & (a_q[i] ^ b_q[i]));
    end
    res_d = WIDTH'({sum, res_q} >> STEP);
  end
  assign last = cnt_q == CW'(N - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q        <= a;
          b_q        <= b ^ {WIDTH{sub}};
          carry_q    <= sub;
          cnt_q      <= '0;
          res_q      <= '0;
          state_q    <= RUN;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        RUN: begin
          a_q     <= a_q >> STEP;
          b_q     <= b_q >> STEP;
          carry_q <= cy[STEP];
          res_q   <= res_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = res_q;
`ifdef SERIAL_ADD_SUB_FLAGS_EN
  logic n_q, z_q, c_q, v_q;
  // On the last RUN cycle cy[STEP-1] is the carry into the MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else if (state_q == RUN && last) begin
      n_q <= res_d[WIDTH-1];
      z_q <= res_d == '0;
      c_q <= cy[STEP];
      v_q <= cy[STEP] ^ cy[STEP-1];
    end
  end
  assign flag_n = n_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;
`else
  assign flag_n = 1'b0;
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: scoreboard bench for serial_add_sub at STEP=1 and STEP=8.
module tb_serial_add_sub;
  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, sub, sel;
  logic [63:0] a, b;
  logic        in_ready1, out_valid1, busy1, n1, z1, c1, v1;
  logic        in_ready8, out_valid8, busy8, n8, z8, c8, v8;
  logic [63:0] result1, result8;
  logic        o_in_ready, o_valid, o_busy;
  logic [63:0] o_res;
  logic [3:0]  o_flags;
  logic [67:0] sb[$];
  int          checks = 0, errs = 0;
  always #5 clk = ~clk;
  serial_add_sub #(.WIDTH(64), .STEP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(in_ready1),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .flag_n(n1), .flag_z(z1), .flag_c(c1), .flag_v(v1), .busy(busy1)
  );
  serial_add_sub #(.WIDTH(64), .STEP(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(in_ready8),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid8), .out_ready(out_ready),
    .result(result8), .flag_n(n8), .flag_z(z8), .flag_c(c8), .flag_v(v8), .busy(busy8)
  );
  always_comb begin
    o_in_ready = sel ? in_ready8 : in_ready1;
    o_valid    = sel ? out_valid8 : out_valid1;
    o_busy     = sel ? busy8 : busy1;
    o_res      = sel ? result8 : result1;
    o_flags    = sel ? {n8, z8, c8, v8} : {n1, z1, c1, v1};
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [67:0] model(input logic [63:0] x, input logic [63:0] y, input logic s);
    logic [63:0] yy;
    logic [64:0] t;
    logic [3:0]  f;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + 65'(s);
    f  = {t[63], t[63:0] == 64'd0, t[64], (x[63] == yy[63]) && (t[63] != x[63])};
`ifndef SERIAL_ADD_SUB_FLAGS_EN
    f = 4'b0;
`endif
    return {f, t[63:0]};
  endfunction
  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic s,
                        input int exp_lat, input int hold);
    logic [67:0] e;
    int lat;
    @(negedge clk);
    a = x; b = y; sub = s; in_valid = 1'b1; out_ready = (hold == 0);
    sb.push_back(model(x, y, s));
    @(posedge clk); #1;
    in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom);
    lat = 0;
    while (!o_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    e = sb.pop_front();
    check("result", o_res, e[63:0]);
    check("nzcv", 64'(o_flags), 64'(e[67:64]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      check("bp_in_ready", 64'(o_in_ready), 64'd0);
      check("bp_result", o_res, e[63:0]);
      check("bp_nzcv", 64'(o_flags), 64'(e[67:64]));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_handshake", 64'({o_in_ready, o_valid, o_busy}), 64'b100);
  endtask
  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; sel = 1'b0; a = '0; b = '0;
    #12;
    check("rst_ctrl", 64'({o_in_ready, o_valid, o_busy}), 64'b100);
    check("rst_result", o_res, 64'd0);
    check("rst_nzcv", 64'(o_flags), 64'd0);
    @(negedge clk); reset = 1'b1;
    run_op(64'd5, 64'd3, 1'b0, 64, 0);
    run_op(64'd5, 64'd5, 1'b1, 64, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64, 0);
    run_op(64'd0, 64'd1, 1'b1, 64, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 1'b0, 64, 10);
    run_op(64'd9, 64'd6, 1'b0, 64, 0);
    for (int i = 0; i < 3; i++)
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 64, 0);
    @(negedge clk);
    a = 64'd77; b = 64'd11; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("abort_ctrl", 64'({o_in_ready, o_valid, o_busy}), 64'b100);
    check("abort_result", o_res, 64'd0);
    @(negedge clk); @(negedge clk); reset = 1'b1;
    run_op(64'd1, 64'd1, 1'b0, 64, 0);
    sel = 1'b1;
    run_op(64'd5, 64'd3, 1'b0, 8, 0);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 8, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Area-reduced ADD/SUB execution unit for the ALU path.
- Processes STEP operand bits per cycle, LSB first, through a ripple of STEP full-adder cells with a registered carry between cycles.
- Produces a WIDTH-bit result plus ARM NZCV flags.
- Sits between the decode/operand-fetch stage (valid/ready input) and the writeback/flag-register stage (valid/ready output).

Parameters:
- WIDTH, 64, operand and result width in bits.
- STEP, 1, bits processed per cycle; WIDTH must be a multiple of STEP (elaboration error otherwise).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  unit can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference.
- flag_n, flag_z, flag_c, flag_v  output  1 each  ARM NZCV flags.
- busy  output  1  high in RUN or DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset forces IDLE and clears all registers.
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, all flags=0.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: capture a; capture b XOR {WIDTH{sub}}; set carry=sub; clear count and result; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, add STEP low bits of the A and B shift registers with carry through chained full adders.
  - Shift the sum bits into result from the MSB end; shift the operands right by STEP; register the carry-out.
  - Count cycles 0..WIDTH/STEP-1; after the final cycle, go to DONE.
- DONE:
  - out_valid=1; result and flags held stable.
  - On out_ready, go to IDLE.
- Latency: out_valid rises exactly WIDTH/STEP rising edges after the accepting edge (64 by default). Throughput is one op per WIDTH/STEP+2 cycles minimum.
- No overlap: in_valid is ignored in RUN and DONE. If in_valid and out_ready are both high in DONE, only the output handshake completes; the new op is accepted in the following IDLE cycle.
- Subtraction is A + ~B + 1, modulo 2^WIDTH.
- Flags, registered when entering DONE:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C = final carry-out. For SUB this means C=1 when no borrow (ARM convention).
  - V = carry into MSB XOR carry out of MSB.
- Reset asserted mid-RUN or in DONE: operation aborted, nothing emitted, state IDLE with reset values; the next accepted op is computed correctly.
- Inputs a, b and sub may change freely after acceptance.

Optional Feature:
- Macro: SERIAL_ADD_SUB_FLAGS_EN.
- Defined: flag_n/z/c/v computed and registered as above.
- Undefined: flag logic and registers not generated; all four flag outputs tied to 0. result, timing and handshake are unchanged.

Test Plan:
- ADD a=5, b=3, sub=0, out_ready=1 (WIDTH=64, STEP=1) -> out_valid exactly 64 edges after acceptance, result=8, NZCV=0000, in_ready=1 the cycle after handshake.
- SUB a=5, b=5 -> result=0, Z=1, C=1, N=0, V=0.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, N=1, V=1, C=0, Z=0.
- SUB a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF, N=1, C=0, V=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid -> result and flags stable, in_ready=0, new op not accepted. Raise out_ready -> IDLE next cycle. Second op (9+6=15) then completes correctly.
- Reset low at cycle 20 of RUN -> out_valid=0, busy=0, in_ready=1 immediately (asynchronous). After release, ADD 1+1 -> result=2. Repeat the first ADD case with STEP=8 -> latency 8 edges, result 8.
